// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rxd, deserialises 8-bit LSB-first frames with optional
// parity, and hands each byte to the register block through a one-entry valid/ready slot.
module uart_rx_core #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             rx_ready,
    input  logic             err_clr,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             rx_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic             rx_s1, rxs, rxs_d;
    logic [2:0]       state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_q, div_eff, half;
    logic             par_en_q, par_odd_q;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             perr, perr_n;
    logic             done_c;
    logic             start_c;

    assign div_eff = (baud_div < DIV_W'(3)) ? DIV_W'(3) : baud_div;
    assign half    = div_q >> 1;
    assign start_c = (state == S_IDLE) && (state_n == S_START);

    // Two-flop synchroniser plus edge register, all idling high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rxs   <= rx_s1;
            rxs_d <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            perr      <= 1'b0;
            div_q     <= DIV_W'(3);
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            perr    <= perr_n;
            rx_busy <= (state_n != S_IDLE);
            if (start_c) begin
                div_q     <= div_eff;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == div_q) ? '0 : cnt + DIV_W'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        perr_n    = perr;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (rxs_d && !rxs) begin
                    state_n = S_START;
                    perr_n  = 1'b0;
                end
            end
            S_START: begin
                // Start bit must still be low at mid-bit, otherwise it was a glitch
                if (cnt == half) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == div_q) begin
                    shift_n   = {rxs, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt == div_q) begin
                    perr_n  = (rxs != ((^shift) ^ par_odd_q));
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed
                if (cnt == div_q) begin
                    done_c  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // One-entry holding slot and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done_c && (!rx_valid || rx_ready)) begin
                rx_valid   <= 1'b1;
                rx_data    <= shift;
                parity_err <= perr;
                frame_err  <= ~rxs;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (done_c && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected bytes, a monitor checks deliveries.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, rx_ready, err_clr;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        parity_err, frame_err, overrun, rx_busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t    q[$];
    exp_t    mon_e;
    int      tests = 0;
    int      fails = 0;
    realtime bit_ns = 8681.0;

    uart_rx_core #(.DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .rx_ready(rx_ready),
        .err_clr(err_clr), .rx_valid(rx_valid), .rx_data(rx_data),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .rx_busy(rx_busy)
    );

    always #31.25 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %02h expected none at %0t", rx_data, $time);
            end else begin
                mon_e = q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(mon_e.d));
                chk("parity_err", 32'(parity_err), 32'(mon_e.pe));
                chk("frame_err", 32'(frame_err), 32'(mon_e.fe));
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic stopb);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(bit_ns);
        end
        if (has_par) begin
            rxd = pbit;
            #(bit_ns);
        end
        rxd = stopb;
        #(bit_ns);
        rxd = 1'b1;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst_n = 1'b0; rxd = 1'b1; baud_div = 16'd138;
        parity_en = 1'b1; parity_odd = 1'b0; rx_ready = 1'b1; err_clr = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk) #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Even parity, clean frame
        expect_byte(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_drain("even_a5_drain");

        // Odd parity with a wrong parity bit
        parity_odd = 1'b1;
        expect_byte(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        wait_drain("odd_3c_drain");

        // All 256 values, correct odd parity, faster bit period
        baud_div = 16'd15;
        bit_ns   = 1000.0;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            expect_byte(b, 1'b0, 1'b0);
            send_frame(b, 1'b1, ~(^b), 1'b1);
        end
        wait_drain("sweep_drain");

        // Framing error, then a short low glitch
        baud_div = 16'd138;
        bit_ns   = 8681.0;
        parity_odd = 1'b0;
        #(bit_ns);
        expect_byte(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        wait_drain("ferr_drain");
        #(2 * bit_ns);
        @(posedge clk) #1 rxd = 1'b0;
        repeat (20) @(posedge clk);
        #1 rxd = 1'b1;
        @(negedge clk);
        chk("glitch_busy_high", 32'(rx_busy), 32'd1);
        repeat (70) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_low", 32'(rx_busy), 32'd0);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);

        // Overrun: second byte dropped while slot full
        parity_en = 1'b0;
        @(posedge clk) #1 rx_ready = 1'b0;
        #(bit_ns);
        expect_byte(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        #(bit_ns);
        @(negedge clk);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'd1);
        @(posedge clk) #1 rx_ready = 1'b1;
        @(posedge clk) #1 rx_ready = 1'b0;
        @(negedge clk);
        chk("ovr_accept_valid", 32'(rx_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        @(posedge clk) #1 err_clr = 1'b1;
        @(posedge clk) #1 err_clr = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        wait_drain("ovr_drain");

        // Back-to-back frames, no parity, zero gap
        @(posedge clk) #1 rx_ready = 1'b1;
        expect_byte(8'h00, 1'b0, 1'b0);
        expect_byte(8'hFF, 1'b0, 1'b0);
        expect_byte(8'h80, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        wait_drain("b2b_drain");

        // Reset during bit 4, then a clean frame
        #(2 * bit_ns);
        b = 8'h5A;
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = b[4];
        #(bit_ns / 2);
        rst_n = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk) #1 rst_n = 1'b1;
        #(2 * bit_ns);
        expect_byte(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_drain("midrst_drain");

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
